seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIG_TICKS, default 100000: cycles each digit is shown; a multiple of 16 and at least 16.
REQ-002 SHALL have parameter DEAD_TICKS, default 500: all-off cycles between digits; at least 1.
REQ-003 ACLK  in  1  single clock; every flop is rising-edge on ACLK.
REQ-004 ARESET  in  1  reset, asynchronous and active-high.
REQ-005 cfg_valid  in  1  one-cycle strobe; captures the cfg_* inputs into the pending set.
REQ-006 cfg_digits  in  16  four hex nibbles; digit k = bits [4k+3:4k].
REQ-007 cfg_dp  in  4  per-digit decimal point on, bit k = digit k.
REQ-008 cfg_blank  in  4  per-digit blank, bit k = digit k.
REQ-009 cfg_bright  in  4  brightness 0..15.
REQ-010 cfg_enable  in  1  scan enable.
REQ-011 cfg_pending  out  1  high while a captured set has not yet been applied.
REQ-012 frame_done  out  1  one-cycle pulse at each frame boundary.
REQ-013 an_n  out  4  anodes, active-low, bit k = digit k.
REQ-014 seg_n  out  7  segments a..g on bits 0..6, active-low.
REQ-015 dp_n  out  1  decimal point, active-low.

Function
REQ-016 SHALL hold two register sets: pending (written by cfg_valid) and active (drives the display); only the active set affects outputs.
REQ-017 cfg_valid SHALL load pending and set cfg_pending on the next edge; a new cfg_valid while cfg_pending=1 overwrites pending (last write wins).
REQ-018 The FSM SHALL have three states: IDLE, SHOW(k), DEAD(k), with k = 0..3.
REQ-019 In IDLE with cfg_pending=1, the FSM SHALL copy pending to active and clear cfg_pending on the next edge.
REQ-020 IDLE SHALL go to SHOW(0) when active enable=1.
REQ-021 SHOW(k) SHALL last exactly DIG_TICKS cycles, then go to DEAD(k).
REQ-022 DEAD(k) SHALL last exactly DEAD_TICKS cycles.
REQ-023 From DEAD(k) with k<3, the FSM SHALL go to SHOW(k+1).
REQ-024 From DEAD(3) (the frame boundary), the FSM SHALL:
  - pulse frame_done;
  - apply pending if cfg_pending=1;
  - go to SHOW(0) if the resulting enable=1, else to IDLE.
REQ-025 cfg_valid in the same cycle as an apply SHALL apply the old pending value; the new value stays pending and cfg_pending stays 1.
REQ-026 SHOW(k) SHALL be split into 16 slots of DIG_TICKS/16 cycles.
REQ-027 an_n[k] SHALL be 0 during slots 0..bright of SHOW(k), else 1. Brightness 15 gives a 100% duty; brightness 0 gives 1/16.
REQ-028 In SHOW(k) with blank[k]=1, an_n SHALL stay 4'hF.
REQ-029 seg_n SHALL be the hex decode (0-F) of nibble k, and dp_n SHALL be ~dp[k], whenever an_n[k]=0.
REQ-030 In IDLE, DEAD and all unlit slots, the outputs SHALL be an_n=4'hF, seg_n=7'h7F, dp_n=1.
REQ-031 All outputs SHALL be registered: one cycle of latency from state/counter to pins, and no anode overlap between digits.
REQ-032 Counter widths SHALL be $clog2 of their limit; counters reset to 0 on every state entry.

Reset
REQ-033 ARESET SHALL asynchronously force:
  - state IDLE, counters 0;
  - pending and active sets all 0, cfg_pending 0, frame_done 0;
  - an_n=4'hF, seg_n=7'h7F, dp_n=1.
REQ-034 ARESET asserted mid-frame SHALL abort the frame with no frame_done pulse; after release the block stays IDLE until enable is applied.

Structure
REQ-035 A package seven_seg_pkg SHALL hold:
  - the state enum;
  - the 16-entry hex-to-segment constant table;
  - a cfg struct {digits, dp, blank, bright, enable}.
REQ-036 The block SHALL contain one combinational sub-module, seven_seg_decode (4-bit in, 7-bit active-low out), built from the package table.

Verification (DIG_TICKS=32, DEAD_TICKS=4)
REQ-037 Reset, then cfg_valid with digits=16'h1234, bright=15, enable=1:
  - an_n cycles E,D,B,7, each low 32 cycles with 4 off cycles between;
  - seg_n per digit = 7'h79 ("1"), 7'h24 ("2"), 7'h30 ("3"), 7'h19 ("4");
  - frame_done pulses every 144 cycles.
REQ-038 bright=3: each anode SHALL be low 8 of 32 cycles (slots 0-3); bright=0: low 2 cycles.
REQ-039 cfg_valid with digits=16'hAAAA mid-frame:
  - cfg_pending SHALL stay 1 until the frame boundary;
  - the change SHALL first appear on digit 0 of the next frame;
  - no mixed frame.
REQ-040 blank=4'b0101, dp=4'b1000: digits 0 and 2 SHALL stay dark; dp_n SHALL be 0 only while an_n=4'h7.
REQ-041 enable=0 written mid-frame SHALL let the current frame finish, pulse frame_done, then go IDLE with all outputs off.
REQ-042 ARESET pulsed during SHOW(2) SHALL drive outputs off asynchronously with no frame_done; the block SHALL remain IDLE after release.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Scan FSM states; the digit index k is held in a separate register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // One complete display configuration (pending or active copy).
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  bright;
    logic        enable;
  } cfg_t;

  // Hex glyphs, active-low, segment a on bit 0 through g on bit 6.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seven_seg_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed four-digit seven-segment scanner with PWM brightness and double-buffered config.
// Latency: one registered cycle from state/counters to pins; config takes effect at the next frame boundary (or at once from IDLE).
// Backpressure: none; a cfg_valid while a set is still pending overwrites it.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIG_TICKS  = 100000,
  parameter int DEAD_TICKS = 500
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_digits,
  input  logic [3:0]  cfg_dp,
  input  logic [3:0]  cfg_blank,
  input  logic [3:0]  cfg_bright,
  input  logic        cfg_enable,
  output logic        cfg_pending,
  output logic        frame_done,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  localparam int SLOT_TICKS = DIG_TICKS / 16;
  // Guard the 1-cycle cases where $clog2 would give a zero-width counter.
  localparam int SLOT_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_TICKS - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);

  state_t             state_q, state_d;
  logic [1:0]         dig_q, dig_d;
  logic [3:0]         slot_q, slot_d;
  logic [SLOT_W-1:0]  tick_q, tick_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;

  cfg_t pending_q, active_q, cfg_in;
  logic apply, frame_end, next_en;
  logic lit;
  logic [3:0] cur_nib;
  logic [6:0] dec_seg;

  assign cfg_in  = {cfg_digits, cfg_dp, cfg_blank, cfg_bright, cfg_enable};
  // Enable that will be in force after a boundary apply.
  assign next_en = cfg_pending ? pending_q.enable : active_q.enable;

  // State and counter registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      dig_q   <= 2'd0;
      slot_q  <= 4'd0;
      tick_q  <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      slot_q  <= slot_d;
      tick_q  <= tick_d;
      dead_q  <= dead_d;
    end
  end

  // Next-state: SHOW runs 16 slots of SLOT_TICKS, DEAD runs DEAD_TICKS; counters restart on each entry.
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    slot_d    = slot_q;
    tick_d    = tick_q;
    dead_d    = dead_q;
    apply     = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        apply = cfg_pending;
        if (active_q.enable) begin
          state_d = ST_SHOW;
          dig_d   = 2'd0;
          slot_d  = 4'd0;
          tick_d  = '0;
        end
      end
      ST_SHOW: begin
        if (tick_q == SLOT_LAST) begin
          tick_d = '0;
          if (slot_q == 4'hF) begin
            state_d = ST_DEAD;
            slot_d  = 4'd0;
            dead_d  = '0;
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end else begin
          tick_d = tick_q + SLOT_W'(1);
        end
      end
      ST_DEAD: begin
        if (dead_q == DEAD_LAST) begin
          dead_d = '0;
          slot_d = 4'd0;
          tick_d = '0;
          if (dig_q == 2'd3) begin
            frame_end = 1'b1;
            apply     = cfg_pending;
            dig_d     = 2'd0;
            state_d   = next_en ? ST_SHOW : ST_IDLE;
          end else begin
            dig_d   = dig_q + 2'd1;
            state_d = ST_SHOW;
          end
        end else begin
          dead_d = dead_q + DEAD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dig_d   = 2'd0;
        slot_d  = 4'd0;
        tick_d  = '0;
        dead_d  = '0;
      end
    endcase
  end

  // Pending/active config sets; apply copies the old pending value even if cfg_valid lands the same cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pending_q   <= '0;
      active_q    <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_valid) begin
        pending_q   <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
      if (apply) begin
        active_q <= pending_q;
      end
    end
  end

  assign cur_nib = active_q.digits[{dig_q, 2'b00} +: 4];
  assign lit     = (state_q == ST_SHOW) && !active_q.blank[dig_q] && (slot_q <= active_q.bright);

  seven_seg_decode u_decode (
    .nibble (cur_nib),
    .seg_n  (dec_seg)
  );

  // Registered pins; everything dark unless the current digit's slot is lit.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      an_n       <= 4'hF;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= lit ? ~(4'b0001 << dig_q) : 4'hF;
      seg_n      <= lit ? dec_seg : SEG_OFF;
      dp_n       <= lit ? ~active_q.dp[dig_q] : 1'b1;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with DIG_TICKS=32, DEAD_TICKS=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scan_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_valid;
  logic [15:0] cfg_digits;
  logic [3:0]  cfg_dp, cfg_blank, cfg_bright;
  logic        cfg_enable;
  logic        cfg_pending, frame_done, dp_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  int checks   = 0;
  int failures = 0;

  seven_seg_scan_ctrl #(.DIG_TICKS(32), .DEAD_TICKS(4)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cfg_valid   (cfg_valid),
    .cfg_digits  (cfg_digits),
    .cfg_dp      (cfg_dp),
    .cfg_blank   (cfg_blank),
    .cfg_bright  (cfg_bright),
    .cfg_enable  (cfg_enable),
    .cfg_pending (cfg_pending),
    .frame_done  (frame_done),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp, blank, bright;
    logic            dbl;
    logic [3:0][7:0] low;
    logic [3:0][6:0] seg;
    logic [3:0][7:0] dpl;
  } vec_t;

  typedef struct {
    logic [3:0][7:0] low;
    logic [3:0][7:0] dpl;
    logic [3:0][6:0] seg;
    bit ovl, dark, segerr, order;
    int len;
    bit have_len;
  } obs_t;

  obs_t obs_q[$];
  vec_t exp_q[$];
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                              input logic [3:0] br, input logic dbl, input logic [31:0] low,
                              input logic [27:0] seg, input logic [31:0] dpl);
    vec_t v;
    v.digits = d; v.dp = dp; v.blank = bl; v.bright = br; v.dbl = dbl;
    v.low = low; v.seg = seg; v.dpl = dpl;
    return v;
  endfunction

  // Monitor: builds one observation record per frame, closed at each frame_done pulse.
  initial begin
    obs_t cur;
    bit [3:0] seen;
    int last_k, cyc, k;
    bit have_prev;
    cur.low = '0; cur.dpl = '0; cur.seg = {4{7'h7F}};
    cur.ovl = 0; cur.dark = 0; cur.segerr = 0; cur.order = 0; cur.len = 0; cur.have_len = 0;
    seen = 0; last_k = -1; cyc = 0; have_prev = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        cur.low = '0; cur.dpl = '0; cur.seg = {4{7'h7F}};
        cur.ovl = 0; cur.dark = 0; cur.segerr = 0; cur.order = 0;
        seen = 0; last_k = -1; cyc = 0; have_prev = 0;
      end else begin
        cyc++;
        if (an_n == 4'hF) begin
          if (seg_n != 7'h7F || dp_n != 1'b1) cur.dark = 1;
        end else if ($countones(~an_n) != 1) begin
          cur.ovl = 1;
        end else begin
          k = 0;
          for (int j = 0; j < 4; j++) if (!an_n[j]) k = j;
          cur.low[k] = cur.low[k] + 8'd1;
          if (seen[k] && cur.seg[k] != seg_n) cur.segerr = 1;
          cur.seg[k] = seg_n;
          seen[k] = 1'b1;
          if (!dp_n) cur.dpl[k] = cur.dpl[k] + 8'd1;
          if (last_k >= 0 && k < last_k) cur.order = 1;
          last_k = k;
        end
        if (frame_done) begin
          cur.len = cyc;
          cur.have_len = have_prev;
          obs_q.push_back(cur);
          cur.low = '0; cur.dpl = '0; cur.seg = {4{7'h7F}};
          cur.ovl = 0; cur.dark = 0; cur.segerr = 0; cur.order = 0;
          seen = 0; last_k = -1; cyc = 0; have_prev = 1;
        end
      end
    end
  end

  task automatic drive(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                       input logic [3:0] br, input logic en);
    @(posedge ACLK); #1;
    cfg_valid = 1'b1; cfg_digits = d; cfg_dp = dp; cfg_blank = bl; cfg_bright = br; cfg_enable = en;
  endtask

  task automatic apply_cfg(input vec_t v, input logic en, input string tag);
    if (v.dbl) drive(16'h0000, 4'hF, 4'h0, 4'h0, en);
    drive(v.digits, v.dp, v.blank, v.bright, en);
    @(posedge ACLK); #1;
    cfg_valid = 1'b0;
    chk({tag, "_pending_set"}, cfg_pending, 1'b1);
  endtask

  // Wait for the pending set to be applied; returns the index of the first frame built from it.
  task automatic wait_apply(input bit exp_fd, input string tag, output int tgt);
    bit done = 0;
    tgt = -1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge ACLK); #1;
      if (!cfg_pending) done = 1;
    end
    if (!done) begin
      chk({tag, "_apply_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({tag, "_fd_at_apply"}, frame_done, exp_fd);
      tgt = frame_done ? obs_q.size() + 1 : obs_q.size();
    end
  endtask

  task automatic run_vec(input int i);
    int tgt;
    bit got = 0;
    string tag;
    vec_t e;
    obs_t o;
    tag = $sformatf("v%0d", i);
    if (i > 0) repeat ($urandom_range(5, 100)) @(posedge ACLK);
    apply_cfg(tbl[i], 1'b1, tag);
    exp_q.push_back(tbl[i]);
    wait_apply(i > 0, tag, tgt);
    if (tgt >= 0) begin
      for (int n = 0; n < 400 && !got; n++) begin
        @(posedge ACLK); #1;
        if (obs_q.size() > tgt) got = 1;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      chk({tag, "_frame_timeout"}, 32'd1, 32'd0);
    end else begin
      o = obs_q[tgt];
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("%s_low%0d", tag, k), o.low[k], e.low[k]);
        chk($sformatf("%s_seg%0d", tag, k), o.seg[k], e.seg[k]);
        chk($sformatf("%s_dp%0d", tag, k), o.dpl[k], e.dpl[k]);
      end
      chk({tag, "_overlap"}, o.ovl, 1'b0);
      chk({tag, "_dark_lines"}, o.dark, 1'b0);
      chk({tag, "_seg_stable"}, o.segerr, 1'b0);
      chk({tag, "_digit_order"}, o.order, 1'b0);
      if (o.have_len) chk({tag, "_frame_len"}, o.len, 32'd144);
    end
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int n_fd = 0, n_on = 0;
    repeat (cycles) begin
      @(posedge ACLK); #1;
      if (frame_done) n_fd++;
      if (an_n != 4'hF || seg_n != 7'h7F || dp_n != 1'b1) n_on++;
    end
    chk({tag, "_no_frame_done"}, n_fd, 32'd0);
    chk({tag, "_outputs_off"}, n_on, 32'd0);
    chk({tag, "_pending_clear"}, cfg_pending, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    bit hit;
    vec_t v;
    // digit k = nibble k; packed fields read {digit3, digit2, digit1, digit0}.
    tbl[0] = mk(16'h1234, 4'h0, 4'h0, 4'hF, 1'b0, {8'd32, 8'd32, 8'd32, 8'd32},
                {7'h79, 7'h24, 7'h30, 7'h19}, 32'h0);
    tbl[1] = mk(16'h1234, 4'h0, 4'h0, 4'h3, 1'b0, {8'd8, 8'd8, 8'd8, 8'd8},
                {7'h79, 7'h24, 7'h30, 7'h19}, 32'h0);
    tbl[2] = mk(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, {8'd2, 8'd2, 8'd2, 8'd2},
                {7'h79, 7'h24, 7'h30, 7'h19}, 32'h0);
    tbl[3] = mk(16'hAAAA, 4'h0, 4'h0, 4'hF, 1'b1, {8'd32, 8'd32, 8'd32, 8'd32},
                {7'h08, 7'h08, 7'h08, 7'h08}, 32'h0);
    tbl[4] = mk(16'h1234, 4'b1000, 4'b0101, 4'hF, 1'b0, {8'd32, 8'd0, 8'd32, 8'd0},
                {7'h79, 7'h7F, 7'h30, 7'h7F}, {8'd32, 8'd0, 8'd0, 8'd0});
    tbl[5] = mk(16'h8F06, 4'b0011, 4'h0, 4'h7, 1'b0, {8'd16, 8'd16, 8'd16, 8'd16},
                {7'h00, 7'h0E, 7'h40, 7'h02}, {8'd0, 8'd0, 8'd16, 8'd16});

    ARESET = 1'b1; cfg_valid = 1'b0; cfg_digits = '0; cfg_dp = '0;
    cfg_blank = '0; cfg_bright = '0; cfg_enable = 1'b0;
    repeat (3) @(posedge ACLK); #1;
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_pending", cfg_pending, 1'b0);
    ARESET = 1'b0;
    quiet_window("idle_after_rst", 20);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Disable mid-frame: the running frame completes, then the block idles dark.
    repeat ($urandom_range(5, 100)) @(posedge ACLK);
    v = tbl[0];
    apply_cfg(v, 1'b0, "dis");
    wait_apply(1'b1, "dis", tgt);
    quiet_window("dis_idle", 300);

    // Reset during SHOW(2): outputs go dark at once, no frame_done, stays idle.
    apply_cfg(v, 1'b1, "rst2");
    wait_apply(1'b0, "rst2", tgt);
    hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(posedge ACLK); #1;
      if (an_n == 4'hB) hit = 1;
    end
    chk("rst2_reach_show2", hit, 1'b1);
    #2 ARESET = 1'b1;
    #1;
    chk("rst2_async_an_n", an_n, 4'hF);
    chk("rst2_async_seg_n", seg_n, 7'h7F);
    chk("rst2_async_dp_n", dp_n, 1'b1);
    chk("rst2_async_fd", frame_done, 1'b0);
    repeat (3) @(posedge ACLK); #1;
    ARESET = 1'b0;
    quiet_window("rst2_idle", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
